// File: rtl/nco_pkg.sv
// nco_core shared types and default widths.
// Optional build macro: NCO_TWOS_COMP_EN (two's complement output).
`timescale 1ns/1ps
package nco_pkg;

  localparam int NCO_ADDR_W  = 10;
  localparam int NCO_DATA_W  = 12;
  localparam int NCO_PHASE_W = 24;
  localparam int NCO_FSTEP_W = 14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_RUN
  } nco_core_state_t;

endpackage

// File: rtl/nco_if.sv
// Table load stream and sample output bundle for nco_core.
// Master drives load data and consumes samples; slave is the core.
`timescale 1ns/1ps
interface nco_if #(
  parameter int DATA_W = 12
);

  logic [DATA_W-1:0] load_data_i;
  logic              load_valid_i;
  logic              nco_load_ready_o;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid_o;

  modport master (
    output load_data_i,
    output load_valid_i,
    input  nco_load_ready_o,
    input  sample_o,
    input  sample_valid_o
  );

  modport slave (
    input  load_data_i,
    input  load_valid_i,
    output nco_load_ready_o,
    output sample_o,
    output sample_valid_o
  );

endinterface

// File: rtl/nco_wave_ram.sv
// Waveform table: one write port, one registered read port.
// Read returns old data on a same-address write collision.
`timescale 1ns/1ps
module nco_wave_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/nco_core.sv
// NCO datapath: table load FSM, phase accumulator, 2-cycle read pipe.
// Build macro NCO_TWOS_COMP_EN flips the output MSB (offset -> 2's comp).
`timescale 1ns/1ps
module nco_core
  import nco_pkg::*;
#(
  parameter int ADDR_W  = NCO_ADDR_W,
  parameter int DATA_W  = NCO_DATA_W,
  parameter int PHASE_W = NCO_PHASE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   nco_we_i,
  input  logic                   nco_en_i,
  input  logic [NCO_FSTEP_W-1:0] nco_freq_step_i,
  nco_if.slave                   io
);

`ifdef NCO_TWOS_COMP_EN
  localparam logic [DATA_W-1:0] OUT_XOR =
    DATA_W'(1) << (DATA_W - 1);
`else
  localparam logic [DATA_W-1:0] OUT_XOR = '0;
`endif

  nco_core_state_t   state;
  logic [ADDR_W-1:0] waddr;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] step_ext;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              wr_en;
  logic              rd_v;
  logic              ready_q;

  assign step_ext = PHASE_W'(nco_freq_step_i);
  assign raddr    = phase[PHASE_W-1 -: ADDR_W];
  assign wr_en    = (state == S_LOAD) && nco_we_i
                 && io.load_valid_i;

  nco_wave_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata (io.load_data_i),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Phase advances on every run cycle, including the exit cycle,
  // so a resumed run continues from the next unsampled phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      waddr   <= '0;
      phase   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (nco_we_i) begin
            state <= S_LOAD;
            waddr <= '0;
            phase <= '0;
          end else if (nco_en_i) begin
            state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (!nco_we_i) begin
            state <= S_IDLE;
          end else if (io.load_valid_i) begin
            waddr <= waddr + ADDR_W'(1);
            if (waddr == '1) begin
              state   <= S_DONE;
              ready_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!nco_we_i) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (nco_we_i) begin
            state <= S_LOAD;
            waddr <= '0;
            phase <= '0;
          end else begin
            phase <= phase + step_ext;
            if (!nco_en_i) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v              <= 1'b0;
      io.sample_valid_o <= 1'b0;
      io.sample_o       <= '0;
    end else begin
      rd_v              <= (state == S_RUN);
      io.sample_valid_o <= rd_v;
      if (rd_v) begin
        io.sample_o <= rdata ^ OUT_XOR;
      end
    end
  end

  assign io.nco_load_ready_o = ready_q;

endmodule
